branch_resolve_unit: RTL

- EX-stage consumer of the branch comparator's `branch_taken` result.
- Resolves branches, JAL and JALR against the direction predicted at ID, and computes the correct next PC.
- Issues a registered one-cycle redirect/flush to fetch/decode.
- Owns the 2-bit saturating branch history table (BHT) that ID reads for its predictions, plus branch/mispredict performance counters.

---
 rtl/branch_resolve_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: redirect, flush, misalign trap,
// 2-bit BHT for ID-stage prediction and branch performance counters.
module branch_resolve_unit #(
  parameter int         BHT_IDX_W = 6,
  parameter logic [1:0] BHT_INIT  = 2'b01,
  parameter int         CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_pc,
  output logic             id_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  input  logic             ex_pred_taken,
  input  logic             branch_taken,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             misalign_exc,
  output logic [31:0]      misalign_addr,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int N = 1 << BHT_IDX_W;

  logic [1:0]       bht_q [N];
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             flush_q, flush_d;
  logic             misalign_exc_q, misalign_exc_d;
  logic [31:0]      misalign_addr_q, misalign_addr_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic             squash_q, squash_d;

  logic                 resolve, actual, mispredict;
  logic                 misalign, redir;
  logic [31:0]          target, fallthrough, correct_pc;
  logic                 bht_we;
  logic [BHT_IDX_W-1:0] bht_idx;
  logic [1:0]           bht_cur, bht_wdata;

  always_comb begin
    resolve     = ex_valid & ~ex_stall & ~squash_q &
                  (ex_is_branch | ex_is_jal | ex_is_jalr);
    actual      = ex_is_branch ? branch_taken : 1'b1;
    target      = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'h1)
                             : (ex_pc + ex_imm);
    fallthrough = ex_pc + 32'd4;
    correct_pc  = actual ? target : fallthrough;

    mispredict = 1'b0;
    unique case (1'b1)
      ex_is_branch: mispredict = actual != ex_pred_taken;
      ex_is_jal:    mispredict = ~ex_pred_taken;
      ex_is_jalr:   mispredict = 1'b1;
      default:      mispredict = 1'b0;
    endcase

    misalign = resolve & actual & target[1];
    redir    = resolve & mispredict & ~misalign;

    redirect_valid_d = redir;
    misalign_exc_d   = misalign;
    flush_d          = redir | misalign;
    redirect_pc_d    = redir ? correct_pc : redirect_pc_q;
    misalign_addr_d  = misalign ? target : misalign_addr_q;

    // wrong-path instr in EX stays dead while it is held by a stall
    squash_d = redir | misalign | (squash_q & ex_stall);

    branch_cnt_d  = branch_cnt_q;
    if (resolve & ex_is_branch)
      branch_cnt_d = branch_cnt_q + 1'b1;
    mispred_cnt_d = mispred_cnt_q;
    if (redir)
      mispred_cnt_d = mispred_cnt_q + 1'b1;

    bht_we  = resolve & ex_is_branch & ~misalign;
    bht_idx = ex_pc[BHT_IDX_W+1:2];
    bht_cur = bht_q[bht_idx];
    if (actual)
      bht_wdata = (bht_cur == 2'b11) ? 2'b11 : bht_cur + 2'd1;
    else
      bht_wdata = (bht_cur == 2'b00) ? 2'b00 : bht_cur - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        bht_q[i] <= BHT_INIT;
    end else if (bht_we) begin
      bht_q[bht_idx] <= bht_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      misalign_exc_q   <= 1'b0;
      misalign_addr_q  <= '0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
      squash_q         <= 1'b0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      misalign_exc_q   <= misalign_exc_d;
      misalign_addr_q  <= misalign_addr_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
      squash_q         <= squash_d;
    end
  end

  // read of registered table gives pre-update value on same-entry write
  assign id_pred_taken  = bht_q[id_pc[BHT_IDX_W+1:2]][1];
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign misalign_exc   = misalign_exc_q;
  assign misalign_addr  = misalign_addr_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{id_pc[31:BHT_IDX_W+2], id_pc[1:0],
                            ex_pc[31:BHT_IDX_W+2], ex_pc[1:0]};

endmodule
